// File: rtl/exu_pkg.sv
// Shared types and constants for the execute-stage controller.
package exu_pkg;

  // Controller state: empty, waiting on the multi-cycle unit, or holding a result
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_WAIT = 2'd1,
    FULL    = 2'd2
  } exu_ctl_state_t;

  // Default multi-cycle watchdog limit in cycles
  localparam int unsigned EXU_MC_TIMEOUT_DEF = 32'd64;

  // Counter value reached on the last permitted wait cycle (the counter starts at 0)
  function automatic logic [15:0] exu_wdt_last(input int unsigned limit);
    exu_wdt_last = 16'(limit - 32'd1);
  endfunction

endpackage

// File: rtl/exu_ctl_wdt.sv
// Multi-cycle watchdog: counts wait cycles and flags the cycle on which the limit is hit.
// Only instantiated when EXU_CTL_TIMEOUT_EN is defined.
module exu_ctl_wdt
  import exu_pkg::*;
#(
  parameter int unsigned LIMIT = EXU_MC_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LAST = exu_wdt_last(LIMIT);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: restart on a new operation, advance on each idle wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 16'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The k-th wait cycle sees count k-1, so expiry is on the LIMIT-th cycle
  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/exu_ctl.sv
// Execute-stage controller: sequences single-cycle ALU results and multi-cycle unit
// operations into a registered valid/ready interface toward the memory stage.
// Optional watchdog on multi-cycle operations enabled by macro EXU_CTL_TIMEOUT_EN.
module exu_ctl
  import exu_pkg::*;
#(
  parameter int unsigned XLEN       = 32'd32,
  parameter int unsigned MC_TIMEOUT = EXU_MC_TIMEOUT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic            id_mc_i,
  input  logic            alu_comp_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            mc_start_o,
  output logic            mc_kill_o,
  input  logic            mc_done_i,
  input  logic [XLEN-1:0] mc_data_i,
  input  logic            flush_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            alu_comp_o,
  output logic [XLEN-1:0] alu_data_o,
  output logic            busy_o,
  output logic            mc_err_o
);

  exu_ctl_state_t  state_q;
  exu_ctl_state_t  state_d;
  logic            comp_q;
  logic            comp_d;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;

  logic            accept_s;
  logic            in_wait_s;
  logic            wdt_expired_s;

  assign in_wait_s  = (state_q == MC_WAIT);
  assign id_ready_o = ((state_q == IDLE) || ((state_q == FULL) && mem_ready_i)) && !flush_i;
  assign accept_s   = id_valid_i && id_ready_o;
  // accept already excludes flush, so a flushed cycle never starts the unit
  assign mc_start_o = accept_s && id_mc_i;

`ifdef EXU_CTL_TIMEOUT_EN
  logic wdt_enable_s;

  assign wdt_enable_s = in_wait_s && !mc_done_i && !flush_i;

  exu_ctl_wdt #(
    .LIMIT (MC_TIMEOUT)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (mc_start_o),
    .enable_i  (wdt_enable_s),
    .expired_o (wdt_expired_s)
  );

  assign mc_err_o = wdt_expired_s;
`else
  logic unused_cfg_s;

  assign unused_cfg_s  = (MC_TIMEOUT != 32'd0);
  assign wdt_expired_s = 1'b0;
  assign mc_err_o      = 1'b0;
`endif

  // Abort the unit on flush or watchdog expiry; depends on state only, so reset never pulses it
  assign mc_kill_o = in_wait_s && (flush_i || wdt_expired_s);

  // Next state and result: flush first, then per-state sequencing
  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = IDLE;
      comp_d  = 1'b0;
      data_d  = {XLEN{1'b0}};
    end else begin
      case (state_q)
        IDLE, FULL: begin
          if (accept_s) begin
            if (id_mc_i) begin
              state_d = MC_WAIT;
            end else begin
              state_d = FULL;
              comp_d  = alu_comp_i;
              data_d  = alu_data_i;
            end
          end else if ((state_q == FULL) && !mem_ready_i) begin
            state_d = FULL;
          end else begin
            state_d = IDLE;
          end
        end
        MC_WAIT: begin
          if (mc_done_i) begin
            state_d = FULL;
            comp_d  = 1'b0;
            data_d  = mc_data_i;
          end else if (wdt_expired_s) begin
            state_d = FULL;
            comp_d  = 1'b0;
            data_d  = {XLEN{1'b0}};
          end else begin
            state_d = MC_WAIT;
          end
        end
        default: begin
          state_d = IDLE;
          comp_d  = 1'b0;
          data_d  = {XLEN{1'b0}};
        end
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      comp_q  <= 1'b0;
      data_q  <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      data_q  <= data_d;
    end
  end

  assign mem_valid_o = (state_q == FULL);
  assign busy_o      = (state_q != IDLE);
  assign alu_comp_o  = comp_q;
  assign alu_data_o  = data_q;

endmodule

// File: tb/tb_exu_ctl.sv
// Self-checking bench for exu_ctl: expected results are queued at issue time and
// popped by a monitor whenever the DUT transfers a result downstream.
module tb_exu_ctl;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            id_valid_i;
  logic            id_ready_o;
  logic            id_mc_i;
  logic            alu_comp_i;
  logic [XLEN-1:0] alu_data_i;
  logic            mc_start_o;
  logic            mc_kill_o;
  logic            mc_done_i;
  logic [XLEN-1:0] mc_data_i;
  logic            flush_i;
  logic            mem_valid_o;
  logic            mem_ready_i;
  logic            alu_comp_o;
  logic [XLEN-1:0] alu_data_o;
  logic            busy_o;
  logic            mc_err_o;

  int n_total = 0;
  int n_pass  = 0;
  int start_cnt = 0;
  int start_base;
  logic [XLEN:0] exp_q[$];

  exu_ctl #(
    .XLEN       (XLEN),
    .MC_TIMEOUT (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .id_valid_i  (id_valid_i),
    .id_ready_o  (id_ready_o),
    .id_mc_i     (id_mc_i),
    .alu_comp_i  (alu_comp_i),
    .alu_data_i  (alu_data_i),
    .mc_start_o  (mc_start_o),
    .mc_kill_o   (mc_kill_o),
    .mc_done_i   (mc_done_i),
    .mc_data_i   (mc_data_i),
    .flush_i     (flush_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .alu_comp_o  (alu_comp_o),
    .alu_data_o  (alu_data_o),
    .busy_o      (busy_o),
    .mc_err_o    (mc_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive point: just after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic comp, input logic [XLEN-1:0] data);
    exp_q.push_back({comp, data});
  endtask

  // Monitor: every downstream transfer must match the oldest queued expectation
  always @(negedge clk_i) begin
    logic [XLEN:0] e;
    if (rst_n_i === 1'b1 && mem_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got comp=%0b data=0x%0h, none expected", alu_comp_o, alu_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("result_comp", 64'(alu_comp_o), 64'(e[XLEN]));
        chk("result_data", 64'(alu_data_o), 64'(e[XLEN-1:0]));
      end
    end
    if (rst_n_i === 1'b1 && mc_start_o === 1'b1) start_cnt++;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i = 1'b0; id_valid_i = 1'b0; id_mc_i = 1'b0; alu_comp_i = 1'b0;
    alu_data_i = 32'h0; mc_done_i = 1'b0; mc_data_i = 32'h0; flush_i = 1'b0;
    mem_ready_i = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", 64'(mem_valid_o), 64'd0);
    chk("rst_comp",  64'(alu_comp_o),  64'd0);
    chk("rst_data",  64'(alu_data_o),  64'd0);
    chk("rst_busy",  64'(busy_o),      64'd0);
    chk("rst_err",   64'(mc_err_o),    64'd0);
    chk("rst_ready", 64'(id_ready_o),  64'd1);
    step(); step();
    rst_n_i = 1'b1;
    step();

    // Single non-mc instruction, 1-cycle latency, then back to idle
    id_valid_i = 1'b1; id_mc_i = 1'b0; alu_comp_i = 1'b1; alu_data_i = 32'h1234_5678;
    mem_ready_i = 1'b1; push(1'b1, 32'h1234_5678);
    step();
    id_valid_i = 1'b0;
    @(negedge clk_i);
    chk("single_valid", 64'(mem_valid_o), 64'd1);
    chk("single_data",  64'(alu_data_o),  64'h1234_5678);
    step();
    @(negedge clk_i);
    chk("single_idle_busy",  64'(busy_o),      64'd0);
    chk("single_idle_valid", 64'(mem_valid_o), 64'd0);
    step();

    // Three back-to-back with a 3-cycle downstream stall after the first
    id_valid_i = 1'b1; alu_comp_i = 1'b0; alu_data_i = 32'hA1A1_0001; mem_ready_i = 1'b0;
    push(1'b0, 32'hA1A1_0001);
    step();
    alu_comp_i = 1'b1; alu_data_i = 32'hA2A2_0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_ready", 64'(id_ready_o),  64'd0);
      chk("stall_valid", 64'(mem_valid_o), 64'd1);
      chk("stall_data",  64'(alu_data_o),  64'hA1A1_0001);
      chk("stall_comp",  64'(alu_comp_o),  64'd0);
      step();
    end
    mem_ready_i = 1'b1; push(1'b1, 32'hA2A2_0002);
    step();
    alu_comp_i = 1'b0; alu_data_i = 32'hA3A3_0003; push(1'b0, 32'hA3A3_0003);
    @(negedge clk_i);
    chk("b2b_ready", 64'(id_ready_o),  64'd1);
    chk("b2b_valid", 64'(mem_valid_o), 64'd1);
    step();
    id_valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_valid3", 64'(mem_valid_o), 64'd1);
    step();
    @(negedge clk_i);
    chk("b2b_idle", 64'(mem_valid_o), 64'd0);

    // Multi-cycle op completing 5 cycles after start
    start_base = start_cnt;
    step();
    id_valid_i = 1'b1; id_mc_i = 1'b1;
    @(negedge clk_i);
    chk("mc_start", 64'(mc_start_o), 64'd1);
    step();
    id_valid_i = 1'b0; id_mc_i = 1'b0; push(1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("mc_wait_busy",  64'(busy_o),      64'd1);
      chk("mc_wait_valid", 64'(mem_valid_o), 64'd0);
      step();
    end
    mc_done_i = 1'b1; mc_data_i = 32'hDEAD_BEEF;
    step();
    mc_done_i = 1'b0; mc_data_i = 32'h0;
    @(negedge clk_i);
    chk("mc_full_busy", 64'(busy_o), 64'd1);
    step();
    chk("mc_start_pulses", 64'(start_cnt - start_base), 64'd1);

    // Stray mc_done while idle is ignored
    mc_done_i = 1'b1; mc_data_i = 32'h0BAD_0BAD;
    step();
    mc_done_i = 1'b0;
    @(negedge clk_i);
    chk("stray_done_valid", 64'(mem_valid_o), 64'd0);
    step();

    // Flush together with mc_done in MC_WAIT
    id_valid_i = 1'b1; id_mc_i = 1'b1;
    step();
    id_valid_i = 1'b0; id_mc_i = 1'b0;
    step();
    flush_i = 1'b1; mc_done_i = 1'b1; mc_data_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    chk("flush_kill",  64'(mc_kill_o),  64'd1);
    chk("flush_ready", 64'(id_ready_o), 64'd0);
    step();
    flush_i = 1'b0; mc_done_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy",  64'(busy_o),      64'd0);
    chk("flush_valid", 64'(mem_valid_o), 64'd0);
    chk("flush_data",  64'(alu_data_o),  64'd0);
    chk("flush_kill_end", 64'(mc_kill_o), 64'd0);
    step();

    // Flush in a stalled FULL with a pending mc request: no start, result cleared
    mem_ready_i = 1'b0; id_valid_i = 1'b1; alu_comp_i = 1'b1; alu_data_i = 32'h7777_7777;
    step();
    id_mc_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_full_start", 64'(mc_start_o), 64'd0);
    step();
    flush_i = 1'b0; id_valid_i = 1'b0; id_mc_i = 1'b0;
    @(negedge clk_i);
    chk("flush_full_valid", 64'(mem_valid_o), 64'd0);
    chk("flush_full_comp",  64'(alu_comp_o),  64'd0);
    step();

    // Non-mc result then mc reload back-to-back, then no mc_done
    mem_ready_i = 1'b1; id_valid_i = 1'b1; alu_comp_i = 1'b1; alu_data_i = 32'h55AA_55AA;
    push(1'b1, 32'h55AA_55AA);
    step();
    id_mc_i = 1'b1;
    @(negedge clk_i);
    chk("reload_mc_start", 64'(mc_start_o), 64'd1);
    step();
    id_valid_i = 1'b0; id_mc_i = 1'b0;
`ifdef EXU_CTL_TIMEOUT_EN
    push(1'b0, 32'h0);
`endif
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
`ifdef EXU_CTL_TIMEOUT_EN
      chk("wdt_err",  64'(mc_err_o),  64'((i == 8) ? 1 : 0));
      chk("wdt_kill", 64'(mc_kill_o), 64'((i == 8) ? 1 : 0));
`else
      chk("nowdt_err",  64'(mc_err_o),  64'd0);
      chk("nowdt_kill", 64'(mc_kill_o), 64'd0);
`endif
      step();
    end
`ifdef EXU_CTL_TIMEOUT_EN
    @(negedge clk_i);
    chk("wdt_full_valid", 64'(mem_valid_o), 64'd1);
    chk("wdt_full_err",   64'(mc_err_o),    64'd0);
    step();
`else
    for (int i = 0; i < 12; i++) step();
    @(negedge clk_i);
    chk("nowdt_still_wait", 64'(busy_o) << 1 | 64'(mem_valid_o), 64'd2);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
`endif

    // Asynchronous reset while holding a result
    mem_ready_i = 1'b0; id_valid_i = 1'b1; alu_comp_i = 1'b1; alu_data_i = 32'hA5A5_A5A5;
    step();
    id_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_valid", 64'(mem_valid_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 64'(mem_valid_o), 64'd0);
    chk("arst_comp",  64'(alu_comp_o),  64'd0);
    chk("arst_data",  64'(alu_data_o),  64'd0);
    chk("arst_busy",  64'(busy_o),      64'd0);
    step();
    rst_n_i = 1'b1;
    step();

    // Reset while waiting on the multi-cycle unit abandons it without a kill
    id_valid_i = 1'b1; id_mc_i = 1'b1;
    step();
    id_valid_i = 1'b0; id_mc_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_wait_busy", 64'(busy_o), 64'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_wait_kill", 64'(mc_kill_o), 64'd0);
    chk("arst_wait_busy", 64'(busy_o),    64'd0);
    step();
    rst_n_i = 1'b1;
    step(); step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
